// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file: one write port, one reserve port,
// NUM_READ packed read ports and the READY status.
interface reg_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) ();
    logic                           WRITE_ENABLE;
    logic [ADDR_WIDTH-1:0]          WRITE_ADDRESS;
    logic [DATA_WIDTH-1:0]          WRITE_DATA;
    logic                           RESERVE_ENABLE;
    logic [ADDR_WIDTH-1:0]          RESERVE_ADDRESS;
    logic [NUM_READ*ADDR_WIDTH-1:0] READ_ADDRESS;
    logic [NUM_READ*DATA_WIDTH-1:0] READ_DATA;
    logic [NUM_READ-1:0]            READ_BUSY;
    logic                           READY;

    modport master (
        output WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA,
        output RESERVE_ENABLE, RESERVE_ADDRESS, READ_ADDRESS,
        input  READ_DATA, READ_BUSY, READY
    );

    modport slave (
        input  WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA,
        input  RESERVE_ENABLE, RESERVE_ADDRESS, READ_ADDRESS,
        output READ_DATA, READ_BUSY, READY
    );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-to-read bypass, pending-write scoreboard
// and a one-entry-per-cycle clear engine started by reset.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic           CLK,
    input  logic           RESET,
    reg_file_sb_if.slave   bus,
    output logic           state_dbg
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0]      pending_q, pending_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            pending_q <= '0;
            mem_q[0]  <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pending_q <= pending_d;
            mem_q     <= mem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        pending_d = pending_q;
        mem_d     = mem_q;
        case (state_q)
            ST_CLEAR: begin
                mem_d[clr_idx_q] = '0;
                clr_idx_d        = clr_idx_q + ADDR_WIDTH'(1);
                if (clr_idx_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_RUN;
            end
            default: begin
                if (bus.WRITE_ENABLE && bus.WRITE_ADDRESS != '0) begin
                    mem_d[bus.WRITE_ADDRESS]     = bus.WRITE_DATA;
                    pending_d[bus.WRITE_ADDRESS] = 1'b0;
                end
                // Applied after the write: a same-cycle reserve is a newer producer.
                if (bus.RESERVE_ENABLE && bus.RESERVE_ADDRESS != '0)
                    pending_d[bus.RESERVE_ADDRESS] = 1'b1;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_READ; i++)
            rd_addr[i] = bus.READ_ADDRESS[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    always_comb begin
        bus.READ_DATA = '0;
        bus.READ_BUSY = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (state_q == ST_RUN && rd_addr[i] != '0) begin
                if (bus.WRITE_ENABLE && bus.WRITE_ADDRESS == rd_addr[i]) begin
                    bus.READ_DATA[i*DATA_WIDTH +: DATA_WIDTH] = bus.WRITE_DATA;
                end else begin
                    bus.READ_DATA[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[i]];
                    bus.READ_BUSY[i] = pending_q[rd_addr[i]];
                end
            end
        end
    end

    assign bus.READY = (state_q == ST_RUN);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_reg_file_sb;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;
  logic state_dbg;

  reg_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rd0, input logic [AW-1:0] rd1);
    bus.WRITE_ENABLE    = we;
    bus.WRITE_ADDRESS   = wa;
    bus.WRITE_DATA      = wd;
    bus.RESERVE_ENABLE  = re;
    bus.RESERVE_ADDRESS = ra;
    bus.READ_ADDRESS    = {rd1, rd0};
  endtask

  task automatic idle_read(input logic [AW-1:0] rd0, input logic [AW-1:0] rd1);
    drive(1'b0, '0, '0, 1'b0, '0, rd0, rd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // ---------------- behavioural model ----------------
  // Clearing is modelled as a countdown that zeroes the whole file when it
  // completes; reads are forced to 0 until then, so intermediate entries are invisible.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  int            m_clear_left = DEPTH;
  bit            m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid      = 1;
      m_clear_left = DEPTH;
      for (int k = 0; k < DEPTH; k++) m_pend[k] = 0;
    end else if (m_valid) begin
      if (m_clear_left > 0) begin
        m_clear_left--;
        if (m_clear_left == 0)
          for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      end else begin
        if (bus.WRITE_ENABLE && bus.WRITE_ADDRESS != 0) begin
          m_mem[bus.WRITE_ADDRESS]  = bus.WRITE_DATA;
          m_pend[bus.WRITE_ADDRESS] = 0;
        end
        if (bus.RESERVE_ENABLE && bus.RESERVE_ADDRESS != 0)
          m_pend[bus.RESERVE_ADDRESS] = 1;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      logic          ready_e;
      logic [AW-1:0] a;
      logic [DW-1:0] d_e;
      logic          b_e;
      ready_e = (m_clear_left == 0);
      exp_q.push_back(DW'(ready_e));
      for (int p = 0; p < NR; p++) begin
        a   = bus.READ_ADDRESS[p*AW +: AW];
        d_e = '0;
        b_e = 1'b0;
        if (ready_e && a != 0) begin
          if (bus.WRITE_ENABLE && bus.WRITE_ADDRESS == a) d_e = bus.WRITE_DATA;
          else begin
            d_e = m_mem[a];
            b_e = m_pend[a];
          end
        end
        exp_q.push_back(d_e);
        exp_q.push_back(DW'(b_e));
      end
      check("ready", DW'(bus.READY), exp_q.pop_front());
      check("state_dbg", DW'(state_dbg), DW'(ready_e));
      for (int p = 0; p < NR; p++) begin
        check($sformatf("rd_data[%0d]", p), bus.READ_DATA[p*DW +: DW], exp_q.pop_front());
        check($sformatf("rd_busy[%0d]", p), DW'(bus.READ_BUSY[p]), exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_read('0, '0);

    // clear sequence
    repeat (3) tick();
    check("ready in reset", DW'(bus.READY), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      settle();
      check("ready during clear", DW'(bus.READY), 32'd0);
      tick();
    end
    settle();
    check("ready after 32 edges", DW'(bus.READY), 32'd1);
    for (int r = 1; r < DEPTH; r++) begin
      idle_read(AW'(r), AW'(DEPTH - r));
      settle();
      check("cleared data", bus.READ_DATA[31:0], 32'd0);
      check("cleared busy", DW'(bus.READ_BUSY[0]), 32'd0);
      tick();
    end

    // basic write/read
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, '0);
    tick();
    idle_read(5'd5, 5'd5);
    settle();
    check("x5 port0", bus.READ_DATA[31:0], 32'hDEAD_BEEF);
    check("x5 port1", bus.READ_DATA[63:32], 32'hDEAD_BEEF);
    check("x5 busy", DW'(bus.READ_BUSY), 32'd0);
    tick();
    drive(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, '0);
    tick();
    idle_read(5'd0, 5'd0);
    settle();
    check("x0 reads 0", bus.READ_DATA[31:0], 32'd0);
    tick();

    // bypass
    drive(1'b1, 5'd8, 32'h11, 1'b0, '0, '0, '0);
    tick();
    drive(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, '0, 5'd7, 5'd8);
    settle();
    check("bypass x7", bus.READ_DATA[31:0], 32'hA5A5_A5A5);
    check("x8 stored", bus.READ_DATA[63:32], 32'h11);
    tick();

    // scoreboard
    drive(1'b0, '0, '0, 1'b1, 5'd9, '0, '0);
    tick();
    idle_read(5'd9, '0);
    settle();
    check("x9 busy after reserve", DW'(bus.READ_BUSY[0]), 32'd1);
    tick();
    drive(1'b1, 5'd9, 32'h77, 1'b0, '0, 5'd9, '0);
    settle();
    check("x9 bypass busy", DW'(bus.READ_BUSY[0]), 32'd0);
    check("x9 bypass data", bus.READ_DATA[31:0], 32'h77);
    tick();
    idle_read(5'd9, '0);
    settle();
    check("x9 busy cleared", DW'(bus.READ_BUSY[0]), 32'd0);
    tick();

    // simultaneous reserve and write
    drive(1'b0, '0, '0, 1'b1, 5'd3, '0, '0);
    tick();
    drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd3, '0, '0);
    tick();
    idle_read(5'd3, '0);
    settle();
    check("x3 data", bus.READ_DATA[31:0], 32'h55);
    check("x3 busy", DW'(bus.READ_BUSY[0]), 32'd1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 5'd0, '0, '0);
    tick();
    idle_read(5'd0, '0);
    settle();
    check("x0 never busy", DW'(bus.READ_BUSY[0]), 32'd0);
    tick();

    // reset mid-operation
    drive(1'b1, 5'd4, 32'h99, 1'b1, 5'd4, '0, '0);
    tick();
    idle_read(5'd4, '0);
    settle();
    check("x4 before reset", bus.READ_DATA[31:0], 32'h99);
    check("x4 busy before reset", DW'(bus.READ_BUSY[0]), 32'd1);
    rst = 1'b1;
    drive(1'b1, 5'd4, 32'hABCD, 1'b1, 5'd4, 5'd4, '0);
    tick();
    rst = 1'b0;
    idle_read(5'd4, '0);
    settle();
    check("ready dropped", DW'(bus.READY), 32'd0);
    check("x4 busy in clear", DW'(bus.READ_BUSY[0]), 32'd0);
    repeat (DEPTH) tick();
    settle();
    check("ready restored", DW'(bus.READY), 32'd1);
    check("x4 cleared", bus.READ_DATA[31:0], 32'd0);
    check("x4 busy cleared", DW'(bus.READ_BUSY[0]), 32'd0);
    tick();

    // randomized traffic, biased to few registers so hazards and bypasses collide
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)),
            $urandom,
            1'($urandom_range(0, 2) == 0),
            AW'($urandom_range(0, 7)),
            AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7)),
            AW'($urandom_range(0, 7)));
      tick();
    end
    rst = 1'b0;
    idle_read('0, '0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port integer register file with write-to-read bypass, a per-register scoreboard (pending-write bits), and a sequential clear engine. It sits in the decode/ID stage of the RV32IM pipeline. Decode reads operands and issues register reservations here; writeback completes them. The block replaces the fixed 32x32, two-read-port register file and adds hazard status per read port.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
- NUM_READ, 2, number of read ports (1..4)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset; starts a clear sequence
- WRITE_ENABLE  in  1  writeback strobe
- WRITE_ADDRESS  in  ADDR_WIDTH  writeback destination
- WRITE_DATA  in  DATA_WIDTH  writeback value
- RESERVE_ENABLE  in  1  decode issues an instruction that will write RESERVE_ADDRESS
- RESERVE_ADDRESS  in  ADDR_WIDTH  destination being reserved
- READ_ADDRESS  in  NUM_READ*ADDR_WIDTH  port i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- READ_DATA  out  NUM_READ*DATA_WIDTH  port i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- READ_BUSY  out  NUM_READ  bit i = 1: port i operand still has a pending writer
- READY  out  1  high when the clear sequence is finished and the file is usable

## Operation
- **States.** The block has two states, CLEAR and RUN. A counter CLR_IDX (ADDR_WIDTH bits) and a PENDING[DEPTH-1:0] vector go with them.
- **RESET=1 at an edge.**
  - State becomes CLEAR, CLR_IDX becomes 0, PENDING becomes all 0, READY becomes 0.
  - Entry 0 is written with 0.
- **CLEAR with RESET=0, each edge.**
  - Entry CLR_IDX is written with 0, then CLR_IDX increments.
  - When CLR_IDX = DEPTH-1, the state becomes RUN and READY becomes 1.
- **Inputs ignored during CLEAR.** WRITE_ENABLE and RESERVE_ENABLE have no effect. READ_DATA is forced to 0 and READ_BUSY to 0.
- **Write (RUN).** When WRITE_ENABLE=1 and WRITE_ADDRESS≠0, at the edge:
  - the entry takes WRITE_DATA;
  - PENDING[WRITE_ADDRESS] clears.
- **Reserve (RUN).** When RESERVE_ENABLE=1 and RESERVE_ADDRESS≠0, PENDING[RESERVE_ADDRESS] sets at the edge.
- **Write and reserve to the same address in one cycle.** Data is written and PENDING ends set, because the reserve belongs to a newer producer.
- **Register 0.**
  - It always reads 0 and READ_BUSY is always 0.
  - Writes and reserves to it are dropped.
- **Read (RUN), combinational, per port i, in priority order:**
  1. address = 0: data 0, busy 0.
  2. WRITE_ENABLE=1 and WRITE_ADDRESS equals the port address: data = WRITE_DATA (bypass), busy 0.
  3. Otherwise: data = stored entry, busy = PENDING[address].
- **Independence of ports.** Read ports are fully independent. Any number of ports may address the same register.

## Timing
- **Reset values.**
  - READY = 0; READ_BUSY = 0; READ_DATA = 0 while in CLEAR.
  - PENDING is all 0. All entries are 0 once READY rises.
- **Clear latency.** Counting from the first edge with RESET=0, entries 0..DEPTH-1 are cleared over DEPTH edges. READY is 1 after the DEPTH-th edge: 32 cycles at ADDR_WIDTH=5.
- **Reset mid-sequence.** RESET=1 during CLEAR or RUN restarts the clear from entry 0 on that edge. Any write or reserve in the same cycle is discarded.
- **Write-to-read latency.**
  - 0 cycles via the bypass in the write cycle.
  - From the next cycle, the value comes from storage.
- **Reserve-to-busy latency.** READ_BUSY goes high on the cycle after RESERVE_ENABLE. There is no same-cycle reserve visibility.
- **Combinational paths.** READ_DATA and READ_BUSY depend combinationally on READ_ADDRESS, WRITE_ENABLE, WRITE_ADDRESS and WRITE_DATA. READY is registered.
- **Write conflicts.** There is a single write port, so none are possible. A write without a prior reserve is legal and leaves PENDING at 0.

## Test plan
- **Clear sequence.** Hold RESET 3 cycles, then release.
  - READY must be 0 for exactly 32 edges, then 1.
  - Reads of x1..x31 then return 0 with READ_BUSY=0.
- **Basic write/read.** Write 0xDEADBEEF to x5, then read x5 on both ports the next cycle.
  - Both ports return 0xDEADBEEF with busy 0.
  - Write 0x1234 to x0; a read of x0 must return 0.
- **Bypass.** In one cycle, write 0xA5A5A5A5 to x7 while port 0 reads x7 and port 1 reads x8 (holding 0x11).
  - Port 0 returns 0xA5A5A5A5 in that same cycle.
  - Port 1 returns 0x11.
- **Scoreboard.** Reserve x9.
  - Next cycle: reading x9 gives busy=1.
  - Write 0x77 to x9 with port 0 reading x9: that cycle gives busy=0 and data 0x77.
  - Next cycle: busy=0.
- **Simultaneous reserve and write.** Reserve x3, then next cycle both write x3=0x55 and reserve x3.
  - The following cycle x3 reads 0x55 with busy=1.
  - Reserving x0 never sets busy.
- **Reset mid-operation.** With x4=0x99 and x4 reserved, assert RESET for 1 cycle while also writing x4.
  - READY drops the next edge and PENDING is cleared.
  - After 32 cycles, READY=1 and x4 reads 0 with busy 0.
